// File: rtl/ct_spsram_param_init.sv
// Single-port SRAM with per-lane write enables and an automatic post-reset init sweep.
// Optional macro CT_SPSRAM_OUT_REG_EN adds a second output register (read latency 2 instead of 1).
module ct_spsram_param_init #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 54,
    parameter int                    WE_WIDTH   = 54,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY,
    output logic                  ACC_ERR
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = DATA_WIDTH / WE_WIDTH;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic                  w_sweep_we;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic                  w_acc_err;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [WE_WIDTH-1:0]   w_lane_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sweep_we   = 1'b0;
        w_acc_wr     = 1'b0;
        w_acc_rd     = 1'b0;
        w_acc_err    = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_we = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                w_acc_err  = ~CEN;
                if (r_cnt == '1) begin
                    w_state_next = ST_READY;
                end
            end
            ST_READY: begin
                w_acc_wr = ~CEN & ~GWEN;
                w_acc_rd = ~CEN & GWEN;
            end
            default: w_state_next = ST_INIT;
        endcase
        // Reset dominates any sweep write or external access in the same cycle.
        if (RST) begin
            w_sweep_we = 1'b0;
            w_acc_wr   = 1'b0;
            w_acc_rd   = 1'b0;
            w_acc_err  = 1'b0;
        end
    end

    assign w_wr_addr = w_sweep_we ? r_cnt : A;
    assign w_wr_data = w_sweep_we ? INIT_VALUE : D;

    generate
        for (genvar gi = 0; gi < WE_WIDTH; gi++) begin : g_lane_we
            assign w_lane_we[gi] = w_sweep_we | (w_acc_wr & ~WEN[gi]);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        for (int i = 0; i < WE_WIDTH; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_wr_addr][i*LANE_W +: LANE_W] <= w_wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read register only loads on a READY read; writes and idle cycles leave it alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd <= '0;
        end else if (w_acc_rd) begin
            r_rd <= r_mem[A];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_acc_err) begin
            r_err <= 1'b1;
        end
    end

`ifdef CT_SPSRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_q_out;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q_out <= '0;
        end else begin
            r_q_out <= r_rd;
        end
    end

    assign Q = r_q_out;
`else
    assign Q = r_rd;
`endif

    assign INIT_BUSY = (r_state == ST_INIT);
    assign ACC_ERR   = r_err;

endmodule
